lcd_result_display: RTL
=======================

LCD_RESULT_DISPLAY -- requirements
Module: lcd_result_display

Interface
REQ-001 Parameter TICK_DIV, default 50000, is the number of clk cycles per LCD step tick (1 ms at 50 MHz).
REQ-002 Parameter PWR_TICKS, default 20, is the number of ticks to wait after reset before the first LCD command.
REQ-003 Port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port LCD_sig, input, 2 bits: result code from the winner-decision stage, synchronous to clk; 00 = playing, 01 = A wins, 10 = B wins, 11 = draw.
REQ-006 Port LCD_E, output, 1 bit: HD44780 enable strobe.
REQ-007 Port LCD_RS, output, 1 bit: register select (0 = command, 1 = data).
REQ-008 Port LCD_RW, output, 1 bit: read/write select; constant 0 (write only).
REQ-009 Port LCD_DATA, output, 8 bits: HD44780 data bus, 8-bit mode.
REQ-010 Port busy, output, 1 bit: 1 whenever the FSM is not in IDLE.

Function
REQ-011 A free-running divider SHALL assert a one-clk tick every TICK_DIV clocks; the FSM SHALL advance only on a tick.
REQ-012 Every byte transfer SHALL take 3 ticks:
- phase 0: RS and DATA driven, E=0
- phase 1: E=1
- phase 2: E=0, RS and DATA held
REQ-013 FSM states SHALL be PWR_WAIT, INIT, CLR_WAIT, IDLE, SET_ADDR and WRITE_CHAR.
REQ-014 PWR_WAIT SHALL last PWR_TICKS ticks with E=0, then go to INIT.
REQ-015 INIT SHALL send these commands in order: 0x38, 0x0C, 0x06, 0x01.
REQ-016 After 0x01 (clear), the FSM SHALL spend 2 idle ticks in CLR_WAIT, then go to SET_ADDR.
REQ-017 SET_ADDR SHALL send command 0x80, then go to WRITE_CHAR.
REQ-018 WRITE_CHAR SHALL send 16 data bytes (RS=1) for the latched code, index 0..15, then go to IDLE.
REQ-019 Messages SHALL be 16 ASCII characters, space-padded:
- 00 = "PLAYING"
- 01 = "PLAYER A WINS"
- 10 = "PLAYER B WINS"
- 11 = "DRAW"
REQ-020 The code SHALL be latched into shown_sig on entry to SET_ADDR; the message SHALL use only shown_sig.
REQ-021 In IDLE, on any tick where LCD_sig differs from shown_sig, the FSM SHALL go to SET_ADDR.
REQ-022 A change of LCD_sig during SET_ADDR or WRITE_CHAR SHALL NOT abort the message; the current message completes, then REQ-021 rewrites it on the next IDLE tick.
REQ-023 The first message after INIT SHALL always be written, whatever the value of LCD_sig.
REQ-024 The character index SHALL be 4 bits and SHALL exit WRITE_CHAR on index 15; it SHALL never wrap past 15.

Reset
REQ-025 When rst=0, all outputs SHALL be driven to 0 asynchronously:
- LCD_E, LCD_RS, LCD_RW and LCD_DATA = 0
- busy = 0 during reset
REQ-026 When rst=0, the internal state SHALL be cleared: FSM = PWR_WAIT, divider = 0, index = 0, shown_sig = 00.
REQ-027 Reset asserted mid-operation (including mid-E-pulse) SHALL drop E in the same instant and restart from PWR_WAIT with the full init sequence.
REQ-028 After rst rises, busy SHALL read 1 until IDLE is first reached.

Structure
REQ-029 A package lcd_pkg SHALL hold:
- the FSM state enum
- LCD_sig code constants
- the command constants 0x38, 0x0C, 0x06, 0x01 and 0x80
- a function mapping (code, index) to an ASCII byte
REQ-030 The tick divider SHALL be a separate sub-module, lcd_tick_gen, parameterised by TICK_DIV; the FSM, sequencing and output registers SHALL stay in lcd_result_display.

Verification (TICK_DIV=4, PWR_TICKS=20)
REQ-031 Reset released with LCD_sig=00:
- E stays 0 for 80 clocks
- then E pulses carry 0x38, 0x0C, 0x06, 0x01, 0x80 with RS=0
- then "PLAYING" plus 9 spaces with RS=1
- then busy falls
REQ-032 E timing: each E high pulse SHALL last exactly 4 clocks, and DATA/RS SHALL be stable from 4 clocks before the E rise to 4 clocks after the E fall.
REQ-033 In IDLE, LCD_sig set to 01: within 2 ticks busy=1, then 0x80 and "PLAYER A WINS" plus 3 spaces are sent; in IDLE with unchanged LCD_sig, no further E pulses occur.
REQ-034 LCD_sig changes 10 to 11 during the 5th character: the full "PLAYER B WINS" message completes, then the FSM rewrites with 0x80 and "DRAW" plus 12 spaces.
REQ-035 rst pulled to 0 while E=1 during WRITE_CHAR: E and DATA drop to 0 immediately; after release, the full 80-clock wait and init sequence repeat.
REQ-036 Code 11 at power-up: the first message is "DRAW" plus 12 spaces, and exactly 16 data strobes are counted.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, command bytes and message text for the HD44780 result display.
// The message ROM is a function so the top can index it by (code, column).
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    CLR_WAIT,
    IDLE,
    SET_ADDR,
    WRITE_CHAR
  } lcd_state_t;

  localparam logic [1:0] SIG_PLAYING = 2'b00;
  localparam logic [1:0] SIG_A_WINS  = 2'b01;
  localparam logic [1:0] SIG_B_WINS  = 2'b10;
  localparam logic [1:0] SIG_DRAW    = 2'b11;

  localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_SET_ADDR   = 8'h80;

  function automatic logic [7:0] init_cmd(input logic [1:0] step);
    logic [7:0] cmd;
    case (step)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_ENTRY_MODE;
      default: cmd = CMD_CLEAR;
    endcase
    return cmd;
  endfunction

  // Column 0 is the leftmost character, held in the top byte of the literal.
  function automatic logic [7:0] msg_char(input logic [1:0] code, input logic [3:0] idx);
    logic [127:0] msg;
    case (code)
      SIG_PLAYING: msg = "PLAYING         ";
      SIG_A_WINS:  msg = "PLAYER A WINS   ";
      SIG_B_WINS:  msg = "PLAYER B WINS   ";
      default:     msg = "DRAW            ";
    endcase
    return msg[8*(4'd15 - idx) +: 8];
  endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Free-running divider producing a one-clock tick every TICK_DIV clocks.
module lcd_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              count <= '0;
    else if (count == LAST) count <= '0;
    else                   count <= count + 1'b1;
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/lcd_result_display.sv
// HD44780 driver: power-up wait, init commands, then rewrites a 16-char result
// message whenever the latched result code disagrees with LCD_sig.
module lcd_result_display
  import lcd_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int PWR_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] LCD_sig,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output logic       busy
);

  localparam logic [15:0] PWR_LAST = 16'(PWR_TICKS - 1);

  lcd_state_t  state, state_nxt;
  logic [1:0]  phase, phase_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [1:0]  shown_sig, shown_nxt;
  logic        tick;
  logic        bus_e, bus_rs;
  logic [7:0]  bus_data;

  lcd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PWR_WAIT;
      phase     <= '0;
      cnt       <= '0;
      idx       <= '0;
      shown_sig <= SIG_PLAYING;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shown_sig <= shown_nxt;
    end
  end

  // Byte-sending states step phase 0..2; the byte finishes on the phase-2 tick.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shown_nxt = shown_sig;
    if (tick) begin
      unique case (state)
        PWR_WAIT: begin
          if (cnt == PWR_LAST) begin
            state_nxt = INIT;
            cnt_nxt   = '0;
            phase_nxt = '0;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        INIT: begin
          if (phase != 2'd2) begin
            phase_nxt = phase + 2'd1;
          end else begin
            phase_nxt = '0;
            if (cnt[1:0] == 2'd3) begin
              state_nxt = CLR_WAIT;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + 16'd1;
            end
          end
        end
        CLR_WAIT: begin
          if (cnt[0]) begin
            state_nxt = SET_ADDR;
            shown_nxt = LCD_sig;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        IDLE: begin
          if (LCD_sig != shown_sig) begin
            state_nxt = SET_ADDR;
            shown_nxt = LCD_sig;
            phase_nxt = '0;
          end
        end
        SET_ADDR: begin
          if (phase != 2'd2) begin
            phase_nxt = phase + 2'd1;
          end else begin
            phase_nxt = '0;
            idx_nxt   = '0;
            state_nxt = WRITE_CHAR;
          end
        end
        WRITE_CHAR: begin
          if (phase != 2'd2) begin
            phase_nxt = phase + 2'd1;
          end else begin
            phase_nxt = '0;
            if (idx == 4'd15) state_nxt = IDLE;
            else              idx_nxt   = idx + 4'd1;
          end
        end
        default: state_nxt = PWR_WAIT;
      endcase
    end
  end

  always_comb begin
    bus_e    = 1'b0;
    bus_rs   = 1'b0;
    bus_data = '0;
    case (state)
      INIT: begin
        bus_data = init_cmd(cnt[1:0]);
        bus_e    = (phase == 2'd1);
      end
      SET_ADDR: begin
        bus_data = CMD_SET_ADDR;
        bus_e    = (phase == 2'd1);
      end
      WRITE_CHAR: begin
        bus_rs   = 1'b1;
        bus_data = msg_char(shown_sig, idx);
        bus_e    = (phase == 2'd1);
      end
      default: ;
    endcase
  end

  // Registered pins keep E glitch-free; async reset drops E mid-pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= '0;
    end else begin
      LCD_E    <= bus_e;
      LCD_RS   <= bus_rs;
      LCD_DATA <= bus_data;
    end
  end

  assign LCD_RW = 1'b0;
  assign busy   = rst & (state != IDLE);

endmodule
